mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mac_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer
//
// Sequences one multiply-accumulate job over an external operand buffer and
// an external MAC unit. A job clears the MAC, streams vec_len operand pairs
// from base_addr upward (wrapping modulo 2^ADDR_W), lets the MAC fold its
// last registered product into the accumulator, then captures the result.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   start       job request, sampled only in IDLE
//   abort       terminate the current job (suppresses a start in IDLE)
//   prec_level  00 full, 01 4-bit weight, 10 2-bit weight, 11 illegal
//   vec_len     number of operand pairs, 0 allowed
//   base_addr   first operand-buffer address
//   rd_en       operand-buffer read strobe
//   rd_addr     operand-buffer read address
//   rd_act      activation, valid the cycle after rd_en
//   rd_wgt      weight, valid the cycle after rd_en
//   mac_en      MAC enable
//   mac_prec    MAC precision select, latched for the job
//   mac_clr_n   active-low MAC clear, driven straight from a flop
//   mac_act     MAC activation
//   mac_wgt     MAC weight
//   mac_result  MAC accumulator output
//   result_out  result captured at the end of a job
//   busy        high in any state other than IDLE
//   done        one-cycle completion pulse
//   err         one-cycle illegal-precision pulse
module mac_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        prec_level,
    input  logic [ADDR_W-1:0] vec_len,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_act,
    input  logic [7:0]        rd_wgt,
    output logic              mac_en,
    output logic [1:0]        mac_prec,
    output logic              mac_clr_n,
    output logic [7:0]        mac_act,
    output logic [7:0]        mac_wgt,
    input  logic [55:0]       mac_result,
    output logic [55:0]       result_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_FEED    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;

    localparam logic [1:0] PREC_ILLEGAL = 2'b11;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    // addr_q is the next address to read; rem_q counts operand pairs still
    // to be fed, so in FEED(k) it holds N-k+1 and reaches 1 on the last pair.
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rem_q;
    logic [1:0]        prec_q;
    logic              clr_n_q;
    logic [55:0]       result_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              last_feed;
    logic              have_data;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign have_data = (rem_q != '0);
    assign last_feed = (rem_q == ADDR_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (prec_level != PREC_ILLEGAL)) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = have_data ? S_FEED : S_CAPTURE;
            end
            S_FEED: begin
                if (last_feed) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            prec_q   <= '0;
            clr_n_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // Clear is asserted for exactly the cycle spent in CLEAR and comes
            // from a flop so the MAC never sees a decode glitch.
            clr_n_q <= (state_nxt != S_CLEAR);

            if (accept) begin
                if (prec_level == PREC_ILLEGAL) begin
                    err_q  <= 1'b1;
                    done_q <= 1'b1;
                end else begin
                    prec_q <= prec_level;
                    rem_q  <= vec_len;
                    addr_q <= base_addr;
                end
            end

            if (!abort) begin
                case (state)
                    S_CLEAR: begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                    S_FEED: begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - ADDR_W'(1);
                    end
                    S_CAPTURE: begin
                        result_q <= mac_result;
                        done_q   <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        mac_en  = 1'b0;
        mac_act = '0;
        mac_wgt = '0;
        case (state)
            S_CLEAR: begin
                rd_en = have_data;
            end
            S_FEED: begin
                rd_en   = !last_feed;
                mac_en  = 1'b1;
                mac_act = rd_act;
                mac_wgt = rd_wgt;
            end
            S_DRAIN: begin
                mac_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rd_addr    = rd_en ? addr_q : '0;
    assign mac_prec   = prec_q;
    assign mac_clr_n  = clr_n_q;
    assign result_out = result_q;
    assign busy       = (state != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [1:0]  prec_level;
    logic [7:0]  vec_len;
    logic [7:0]  base_addr;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_act;
    logic [7:0]  rd_wgt;
    logic        mac_en;
    logic [1:0]  mac_prec;
    logic        mac_clr_n;
    logic [7:0]  mac_act;
    logic [7:0]  mac_wgt;
    logic [55:0] mac_result;
    logic [55:0] result_out;
    logic        busy;
    logic        done;
    logic        err;

    mac_sequencer #(.ADDR_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .prec_level (prec_level),
        .vec_len    (vec_len),
        .base_addr  (base_addr),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_act     (rd_act),
        .rd_wgt     (rd_wgt),
        .mac_en     (mac_en),
        .mac_prec   (mac_prec),
        .mac_clr_n  (mac_clr_n),
        .mac_act    (mac_act),
        .mac_wgt    (mac_wgt),
        .mac_result (mac_result),
        .result_out (result_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand buffer: one-cycle read latency.
    logic [7:0] mem_act [0:255];
    logic [7:0] mem_wgt [0:255];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_act <= mem_act[rd_addr];
            rd_wgt <= mem_wgt[rd_addr];
        end
    end

    // MAC: registered product, then lane-wise accumulate.
    logic [55:0] m_prod;
    logic [55:0] m_acc;

    function automatic logic [55:0] mac_prod(input logic [7:0] a, input logic [7:0] w,
                                             input logic [1:0] p);
        logic [55:0]        r;
        logic signed [55:0] t;
        logic signed [27:0] u;
        logic signed [13:0] v;
        r = '0;
        case (p)
            2'b01: begin
                u = 28'($signed(a)) * 28'($signed(w[7:4]));
                r[55:28] = u;
                u = 28'($signed(a)) * 28'($signed(w[3:0]));
                r[27:0] = u;
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    v = 14'($signed(a)) * 14'($signed(w[2*i +: 2]));
                    r[14*i +: 14] = v;
                end
            end
            default: begin
                t = 56'($signed(a)) * 56'($signed(w));
                r = t;
            end
        endcase
        return r;
    endfunction

    function automatic logic [55:0] mac_add(input logic [55:0] acc, input logic [55:0] prod,
                                            input logic [1:0] p);
        logic [55:0] r;
        r = '0;
        case (p)
            2'b01: begin
                r[55:28] = acc[55:28] + prod[55:28];
                r[27:0]  = acc[27:0] + prod[27:0];
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    r[14*i +: 14] = acc[14*i +: 14] + prod[14*i +: 14];
                end
            end
            default: r = acc + prod;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_prod <= '0;
            m_acc  <= '0;
        end else if (!mac_clr_n) begin
            m_prod <= '0;
            m_acc  <= '0;
        end else if (mac_en) begin
            m_prod <= mac_prod(mac_act, mac_wgt, mac_prec);
            m_acc  <= mac_add(m_acc, m_prod, mac_prec);
        end
    end

    assign mac_result = m_acc;

    // Running event counters, sampled away from the active edge.
    int n_rd, n_mac, n_clr, n_done, n_err;
    int s_rd, s_mac, s_clr, s_done, s_err;

    initial begin
        n_rd = 0; n_mac = 0; n_clr = 0; n_done = 0; n_err = 0;
    end

    always @(negedge clk) begin
        if (rd_en)      n_rd   = n_rd + 1;
        if (mac_en)     n_mac  = n_mac + 1;
        if (!mac_clr_n) n_clr  = n_clr + 1;
        if (done)       n_done = n_done + 1;
        if (err)        n_err  = n_err + 1;
    end

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [7:0] base, input logic [7:0] n, input logic [7:0] a0,
                        input logic [7:0] astep, input logic [7:0] w);
        logic [7:0] ad;
        logic [7:0] av;
        for (int i = 0; i < 256; i++) begin
            mem_act[i] = '0;
            mem_wgt[i] = '0;
        end
        ad = base;
        av = a0;
        for (int i = 0; i < int'(n); i++) begin
            mem_act[ad] = av;
            mem_wgt[ad] = w;
            ad = ad + 8'd1;
            av = av + astep;
        end
    endtask

    // Called #1 after a rising edge. Returns the number of edges after the
    // start-sampling edge until done is seen (40 means it never came).
    // With poke set, an illegal start is driven while the job is running.
    task automatic run_job(input logic [1:0] p, input logic [7:0] n, input logic [7:0] base,
                           input logic [7:0] a0, input logic [7:0] astep, input logic [7:0] w,
                           input bit poke, output int edges);
        fill(base, n, a0, astep, w);
        s_rd = n_rd; s_mac = n_mac; s_clr = n_clr; s_done = n_done; s_err = n_err;
        prec_level = p;
        vec_len    = n;
        base_addr  = base;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges = edges + 1;
            if (poke && edges == 1) begin
                start      = 1'b1;
                prec_level = 2'b11;
                vec_len    = 8'd0;
            end
            if (poke && edges == 2) begin
                start = 1'b0;
            end
        end
    endtask

    int          edges;
    logic [55:0] exp56;

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rstn       = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        prec_level = 2'b00;
        vec_len    = 8'd0;
        base_addr  = 8'd0;
        fill(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_err",    err, 0);
        check("rst_rd_en",  rd_en, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_clr_n",  mac_clr_n, 0);
        check("rst_result", result_out, 0);
        check("rst_prec",   mac_prec, 0);
        check("rst_act",    mac_act, 0);
        check("rst_wgt",    mac_wgt, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_clr_n", mac_clr_n, 1);

        // Full precision, 3 x (3*5).
        run_job(2'b00, 8'd3, 8'h10, 8'd3, 8'd0, 8'd5, 1'b0, edges);
        check("full_result", result_out, 45);
        check("full_edges",  edges, 6);
        check("full_rd",     n_rd - s_rd, 3);
        check("full_mac",    n_mac - s_mac, 4);
        check("full_clr",    n_clr - s_clr, 1);
        check("full_busy",   busy, 0);
        @(posedge clk);
        #1;
        check("full_done_pulse", done, 0);

        // 2-bit weights: four lanes of 2.
        run_job(2'b10, 8'd2, 8'h20, 8'd1, 8'd0, 8'h55, 1'b0, edges);
        exp56 = {14'd2, 14'd2, 14'd2, 14'd2};
        check("p2_result", result_out, exp56);
        check("p2_edges",  edges, 5);
        @(posedge clk);
        #1;
        check("p2_prec_idle", mac_prec, 2'b10);

        // 4-bit weights, act=-2, wgt nibbles 1 and 3.
        run_job(2'b01, 8'd1, 8'h08, 8'hFE, 8'd0, 8'h13, 1'b0, edges);
        exp56 = {28'hFFFFFFE, 28'hFFFFFFA};
        check("p4_result", result_out, exp56);
        check("p4_edges",  edges, 4);

        // Illegal precision: err and done together, nothing else moves.
        run_job(2'b11, 8'd2, 8'h00, 8'd1, 8'd0, 8'd1, 1'b0, edges);
        check("ill_edges",  edges, 0);
        check("ill_err",    err, 1);
        check("ill_busy",   busy, 0);
        check("ill_result", result_out, exp56);
        check("ill_prec",   mac_prec, 2'b01);
        @(posedge clk);
        #1;
        check("ill_err_pulse", err, 0);
        check("ill_rd",    n_rd - s_rd, 0);
        check("ill_mac",   n_mac - s_mac, 0);
        check("ill_clr",   n_clr - s_clr, 0);
        check("ill_errcnt", n_err - s_err, 1);

        // Empty vector.
        run_job(2'b00, 8'd0, 8'h30, 8'd0, 8'd0, 8'd0, 1'b0, edges);
        check("n0_result", result_out, 0);
        check("n0_edges",  edges, 2);
        check("n0_clr",    n_clr - s_clr, 1);
        check("n0_rd",     n_rd - s_rd, 0);
        check("n0_mac",    n_mac - s_mac, 0);

        // Address wrap FE,FF,00 with acts 1,2,3 and weight -1.
        run_job(2'b00, 8'd3, 8'hFE, 8'd1, 8'd1, 8'hFF, 1'b0, edges);
        check("wrap_result", result_out, 56'hFF_FFFF_FFFF_FFFA);
        check("wrap_edges",  edges, 6);

        // Start while busy is ignored.
        run_job(2'b00, 8'd3, 8'h10, 8'd3, 8'd0, 8'd5, 1'b1, edges);
        check("busy_start_result", result_out, 45);
        check("busy_start_edges",  edges, 6);
        check("busy_start_err",    n_err - s_err, 0);

        // Abort during FEED(2).
        fill(8'h50, 8'd4, 8'd1, 8'd0, 8'd1);
        prec_level = 2'b00;
        vec_len    = 8'd4;
        base_addr  = 8'h50;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_busy",   busy, 1);
        check("abort_pre_mac_en", mac_en, 1);
        s_done = n_done;
        abort  = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy",   busy, 0);
        check("abort_mac_en", mac_en, 0);
        check("abort_rd_en",  rd_en, 0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", n_done - s_done, 0);
        check("abort_result",  result_out, 45);

        // Start and abort together in IDLE.
        s_done     = n_done;
        prec_level = 2'b00;
        vec_len    = 8'd2;
        start      = 1'b1;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy",  busy, 0);
        check("sa_clr_n", mac_clr_n, 1);
        repeat (3) @(posedge clk);
        #1;
        check("sa_no_done", n_done - s_done, 0);

        // Reset during FEED(2) of a 4-pair job, then a fresh job.
        fill(8'h40, 8'd4, 8'd1, 8'd0, 8'd1);
        prec_level = 2'b01;
        vec_len    = 8'd4;
        base_addr  = 8'h40;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_pre_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy",   busy, 0);
        check("mid_rst_rd_en",  rd_en, 0);
        check("mid_rst_mac_en", mac_en, 0);
        check("mid_rst_act",    mac_act, 0);
        check("mid_rst_clr_n",  mac_clr_n, 0);
        check("mid_rst_result", result_out, 0);
        check("mid_rst_prec",   mac_prec, 0);
        check("mid_rst_done",   done, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_clr_n_up", mac_clr_n, 1);
        run_job(2'b00, 8'd1, 8'h60, 8'd2, 8'd0, 8'd2, 1'b0, edges);
        check("after_rst_result", result_out, 4);
        check("after_rst_edges",  edges, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
